// File: rtl/csa_mul_pkg.sv
// Shared definitions for the carry-save sequential multiplier:
// FSM state encoding and the default operand widths.
package csa_mul_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMPRESS = 2'd1,
    RESOLVE  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int A_W_DEF = 8;
  localparam int B_W_DEF = 16;

endpackage

// File: rtl/compressor3to2.sv
// Single-bit 3:2 compressor (full adder without carry chaining).
module compressor3to2 (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_row.sv
// One combinational carry-save row: folds a partial product into the
// redundant (sum, carry) pair. The carry out of the MSB position is
// discarded by the shift; it is always zero for in-range operands.
module csa_row #(
  parameter int W = 24
) (
  input  logic [W-1:0] sum,
  input  logic [W-1:0] carry,
  input  logic [W-1:0] pp,
  output logic [W-1:0] sum_next,
  output logic [W-1:0] carry_next
);

  logic [W-1:0] maj;

  for (genvar i = 0; i < W; i++) begin : g_bit
    compressor3to2 u_cmp (
      .x (sum[i]),
      .y (carry[i]),
      .z (pp[i]),
      .s (sum_next[i]),
      .c (maj[i])
    );
  end

  assign carry_next = maj << 1;

endmodule

// File: rtl/csa_mul_seq.sv
// Sequential shift-and-add multiplier that accumulates partial products in
// carry-save form (one compressor row per cycle) and resolves the redundant
// pair with a single carry-propagate add at the end.
// Optional build macro CSA_MUL_EARLY_EXIT_EN: leave the compress phase as
// soon as no set multiplier bits remain (at least one compress cycle).
module csa_mul_seq
  import csa_mul_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               busy,
  output logic               done,
  output logic [A_W+B_W-1:0] product
);

  localparam int PW    = A_W + B_W;
  localparam int CNT_W = $clog2(A_W + 1);

  state_t           state, state_next;
  logic [A_W-1:0]   a_reg;
  logic [B_W-1:0]   b_reg;
  logic [PW-1:0]    sum, carry;
  logic [PW-1:0]    sum_next, carry_next;
  logic [PW-1:0]    b_ext, pp;
  logic [CNT_W-1:0] count;
  logic             a_bit;
  logic             last_cycle;

  // Partial product for the current multiplier bit.
  assign a_bit = ((a_reg >> count) & A_W'(1)) != '0;
  assign b_ext = {{A_W{1'b0}}, b_reg};
  assign pp    = a_bit ? (b_ext << count) : '0;

`ifdef CSA_MUL_EARLY_EXIT_EN
  assign last_cycle = ((a_reg >> (count + 1'b1)) == '0) || (count == CNT_W'(A_W - 1));
`else
  assign last_cycle = (count == CNT_W'(A_W - 1));
`endif

  csa_row #(
    .W (PW)
  ) u_row (
    .sum        (sum),
    .carry      (carry),
    .pp         (pp),
    .sum_next   (sum_next),
    .carry_next (carry_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = COMPRESS;
      end
      COMPRESS: if (last_cycle) state_next = RESOLVE;
      RESOLVE:  state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // Operand capture, carry-save accumulation and final resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum     <= '0;
      carry   <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            sum   <= '0;
            carry <= '0;
            count <= '0;
          end
        end
        COMPRESS: begin
          sum   <= sum_next;
          carry <= carry_next;
          count <= count + 1'b1;
        end
        RESOLVE: product <= sum + carry;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_mul_seq.sv
// Bench for csa_mul_seq: directed vector table, multi-cycle corner
// sequences (held start, aborts by reset) and a sweep of every multiplier
// value against random multiplicands, all compared with plain a*b and a
// latency model derived from the multiplier bit length.
module tb_csa_mul_seq;

  localparam int A_W = 8;
  localparam int B_W = 16;
  localparam int PW  = A_W + B_W;

  logic          clk;
  logic          reset;
  logic          start;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  int errs   = 0;
  int checks = 0;

  csa_mul_seq #(
    .A_W (A_W),
    .B_W (B_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [PW-1:0]  p;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge (counted from the accepting edge) on which done is seen.
  function automatic int exp_lat(input logic [A_W-1:0] av);
    int n;
`ifdef CSA_MUL_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < A_W; i++) if (av[i]) n = i + 1;
`else
    n = A_W;
`endif
    return n + 1;
  endfunction

  // One full transaction: accept, watch busy each cycle, check latency,
  // result and the return to IDLE.
  task automatic do_op(input logic [A_W-1:0] av, input logic [B_W-1:0] bv,
                       input logic [PW-1:0] ep, input string name);
    int  lat;
    bit  got;
    lat   = 0;
    got   = 0;
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_busy_acc"}, busy, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k;
        got = 1;
        break;
      end
      if (busy !== 1'b1) check({name, "_busy_mid"}, busy, 1'b1);
    end
    check({name, "_timeout"}, got, 1'b1);
    check({name, "_lat"}, lat, exp_lat(av));
    check({name, "_prod"}, product, ep);
    check({name, "_busy_done"}, busy, 1'b1);
    tick();
    check({name, "_done_width"}, done, 1'b0);
    check({name, "_idle"}, busy, 1'b0);
    check({name, "_prod_held"}, product, ep);
  endtask

  vec_t tbl[7];

  initial begin
    int lat;
    int p;
    int dn;
    logic [B_W-1:0] rb;
    logic [PW-1:0]  ep;

    tbl[0] = '{a: 8'h00, b: 16'hFFFF, p: 24'h000000};
    tbl[1] = '{a: 8'hFF, b: 16'hFFFF, p: 24'hFEFF01};
    tbl[2] = '{a: 8'h03, b: 16'h0005, p: 24'h00000F};
    tbl[3] = '{a: 8'h01, b: 16'h1234, p: 24'h001234};
    tbl[4] = '{a: 8'h80, b: 16'h8000, p: 24'h400000};
    tbl[5] = '{a: 8'hAA, b: 16'h5555, p: 24'h38AA72};
    tbl[6] = '{a: 8'hFF, b: 16'h0001, p: 24'h0000FF};

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_prod", product, 24'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) do_op(tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("vec%0d", i));

    // Start held high: operands change while busy and must not be taken;
    // a new operation begins only in the IDLE cycle after DONE.
    lat   = exp_lat(8'h03);
    a     = 8'h03;
    b     = 16'h0005;
    start = 1'b1;
    tick();
    a = 8'hFF;
    b = 16'hFFFF;
    for (int e = 1; e < 12; e++) begin
      tick();
      p = e % (lat + 2);
      check($sformatf("held_busy_e%0d", e), busy, (p != lat + 1));
      check($sformatf("held_done_e%0d", e), done, (p == lat));
      if (p == lat) begin
        check($sformatf("held_prod_e%0d", e), product, 24'h00000F);
        a = 8'h03;
        b = 16'h0005;
      end
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Reset in COMPRESS with count=4.
    do_op(8'hFF, 16'hFFFF, 24'hFEFF01, "pre_abort");
    a     = 8'hFF;
    b     = 16'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_c_busy", busy, 1'b0);
    check("abort_c_done", done, 1'b0);
    check("abort_c_prod", product, 24'h0);
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) dn++;
    end
    check("abort_c_nodone", dn, 0);

    // Reset while in RESOLVE.
    do_op(8'hAA, 16'h5555, 24'h38AA72, "pre_abort_r");
    lat   = exp_lat(8'h0F);
    a     = 8'h0F;
    b     = 16'h7777;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (lat - 1) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_r_busy", busy, 1'b0);
    check("abort_r_done", done, 1'b0);
    check("abort_r_prod", product, 24'h0);
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) dn++;
    end
    check("abort_r_nodone", dn, 0);

    // Every multiplier value against a random multiplicand.
    for (int i = 0; i < 256; i++) begin
      rb = B_W'($urandom);
      ep = PW'(i) * PW'(rb);
      do_op(i[A_W-1:0], rb, ep, $sformatf("sweep_a%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
